// File: rtl/max10nios_irq_aggregator.sv
// Avalon-MM interrupt aggregator: synchronises NUM_IRQ requests, latches edge-mode
// sources, masks them and drives one registered irq plus a lowest-pending ID readback.
module max10nios_irq_aggregator #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);
    localparam int unsigned PAD = 16 - NUM_IRQ;

    typedef enum logic [2:0] {
        REG_PENDING   = 3'd0,
        REG_MASK      = 3'd1,
        REG_EDGE      = 3'd2,
        REG_ACTIVE_ID = 3'd3,
        REG_RAW       = 3'd4,
        REG_FORCE     = 3'd5
    } reg_addr_e;

    logic [NUM_IRQ-1:0] s1, s2, s3;
    logic [NUM_IRQ-1:0] lat, mask_r, edge_r;
    logic [NUM_IRQ-1:0] wdata, rise, pending, active;
    logic [NUM_IRQ-1:0] lat_set, lat_clr;
    logic               wr;
    logic               active_valid;
    logic [3:0]         active_id;
    logic [15:0]        rd_next;
    logic               unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[NUM_IRQ-1:0];
    assign unused_wdata = ^writedata[15:NUM_IRQ];
    assign rise         = s2 & ~s3;
    assign pending      = (edge_r & lat) | (~edge_r & s2);
    assign active       = pending & mask_r;

    // Latch only edge-mode bits, so inputs high at reset release stay level-high.
    always_comb begin
        lat_set = rise;
        lat_clr = '0;
        if (wr && address == REG_FORCE)
            lat_set = lat_set | wdata;
        lat_set = lat_set & edge_r;
        if (wr && address == REG_PENDING)
            lat_clr = lat_clr | wdata;
        if (wr && address == REG_EDGE)
            lat_clr = lat_clr | (wdata ^ edge_r);
    end

    always_comb begin
        active_valid = 1'b0;
        active_id    = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (active[i] && !active_valid) begin
                active_valid = 1'b1;
                active_id    = 4'(i);
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            REG_PENDING:   rd_next = {{PAD{1'b0}}, pending};
            REG_MASK:      rd_next = {{PAD{1'b0}}, mask_r};
            REG_EDGE:      rd_next = {{PAD{1'b0}}, edge_r};
            REG_ACTIVE_ID: rd_next = {active_valid, 11'b0, active_id};
            REG_RAW:       rd_next = {{PAD{1'b0}}, s2};
            default:       rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            lat      <= '0;
            mask_r   <= '0;
            edge_r   <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            s1       <= irq_in;
            s2       <= s1;
            s3       <= s2;
            // Set wins over a same-cycle clear so a colliding edge is never lost.
            lat      <= (lat & ~lat_clr) | lat_set;
            if (wr && address == REG_MASK)
                mask_r <= wdata;
            if (wr && address == REG_EDGE)
                edge_r <= wdata;
            irq      <= |active;
            readdata <= rd_next;
        end
    end
endmodule

// File: tb/tb_max10nios_irq_aggregator.sv
// Self-checking bench for max10nios_irq_aggregator: read results go through an
// expected-value queue, irq timing is checked against fixed pipeline latencies.
module tb_max10nios_irq_aggregator;
    localparam int unsigned NUM_IRQ    = 8;
    localparam int unsigned TIMER_LOAD = 4999;  // period scaled down to keep runtime short
    localparam int unsigned ISR_DELAY  = 20;

    logic               clk = 1'b0;
    logic               reset;
    logic [2:0]         address;
    logic               chipselect;
    logic               write_n;
    logic [15:0]        writedata;
    logic [15:0]        readdata;
    logic [NUM_IRQ-1:0] irq_in;
    logic               irq;

    logic [15:0] exp_q[$];
    logic [15:0] e;
    int n_vec = 0;
    int n_err = 0;

    max10nios_irq_aggregator #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, irq=%b", irq);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] expv);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        irq_in  = 8'hFF;
        address = 3'd4;
        tick(2);
        n_vec++;
        if (readdata !== 16'h0000) begin
            n_err++; $display("FAIL t1_readdata_in_reset: got %h required 0000", readdata);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL t1_irq_in_reset: got %b required 0", irq);
        end
        reset = 1'b0;
        tick(2);
        for (int unsigned a = 0; a < 8; a++) begin
            rd(3'(a), (a == 0 || a == 4) ? 16'h00FF : 16'h0000);
            e = exp_q.pop_front(); n_vec++;
            if (readdata !== e) begin
                n_err++; $display("FAIL t1_read_addr%0d: got %h required %h", a, readdata, e);
            end
            n_vec++;
            if (irq !== 1'b0) begin
                n_err++; $display("FAIL t1_irq_after_reset: got %b required 0", irq);
            end
        end
        irq_in = '0;
        tick(3);
    endtask

    task automatic test_level;
        wr(3'd1, 16'h0001);
        wr(3'd2, 16'h0000);
        irq_in = 8'h01;
        tick(2);
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL t2_irq_early: got %b required 0", irq);
        end
        tick(1);
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL t2_irq_rise: got %b required 1", irq);
        end
        rd(3'd3, 16'h8000);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL t2_active_id: got %h required %h", readdata, e);
        end
        irq_in = 8'h00;
        tick(2);
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL t2_irq_hold: got %b required 1", irq);
        end
        tick(1);
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL t2_irq_fall: got %b required 0", irq);
        end
    endtask

    task automatic test_edge_latch;
        wr(3'd1, 16'h000C);
        wr(3'd2, 16'h000C);
        irq_in = 8'h08; tick(1);
        irq_in = 8'h00; tick(1);
        irq_in = 8'h04; tick(1);
        irq_in = 8'h00; tick(4);
        rd(3'd0, 16'h000C);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL t3_pending: got %h required %h", readdata, e);
        end
        rd(3'd3, 16'h8002);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL t3_active_id2: got %h required %h", readdata, e);
        end
        wr(3'd0, 16'h0004);
        rd(3'd3, 16'h8003);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL t3_active_id3: got %h required %h", readdata, e);
        end
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL t3_irq_one_left: got %b required 1", irq);
        end
        wr(3'd0, 16'h0008);
        tick(1);
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL t3_irq_cleared: got %b required 0", irq);
        end
        rd(3'd0, 16'h0000);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL t3_pending_cleared: got %h required %h", readdata, e);
        end
    endtask

    task automatic test_collision;
        wr(3'd1, 16'h0002);
        wr(3'd2, 16'h0002);
        irq_in = 8'h02;
        tick(2);
        wr(3'd0, 16'h0002);
        tick(1);
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL t4_irq_kept: got %b required 1", irq);
        end
        rd(3'd0, 16'h0002);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL t4_pending_kept: got %h required %h", readdata, e);
        end
        irq_in = 8'h00;
        tick(3);
        wr(3'd0, 16'h0002);
        tick(1);
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL t4_irq_w1c: got %b required 0", irq);
        end
    endtask

    task automatic test_mask_force;
        wr(3'd2, 16'h0010);
        wr(3'd1, 16'h0000);
        wr(3'd5, 16'h0030);
        rd(3'd0, 16'h0010);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL t5_pending_forced: got %h required %h", readdata, e);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL t5_irq_masked: got %b required 0", irq);
        end
        wr(3'd1, 16'h0010);
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL t5_irq_unmask_early: got %b required 0", irq);
        end
        tick(1);
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL t5_irq_unmask: got %b required 1", irq);
        end
        rd(3'd3, 16'h8004);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL t5_active_id: got %h required %h", readdata, e);
        end
    endtask

    task automatic test_boundary;
        logic [2:0]  addrs[6] = '{3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd2};
        logic [15:0] expd[6]  = '{16'h8004, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0010};
        wr(3'd3, 16'hFFFF);
        wr(3'd4, 16'hFFFF);
        wr(3'd6, 16'hFFFF);
        wr(3'd7, 16'hFFFF);
        for (int unsigned k = 0; k < 6; k++) begin
            rd(addrs[k], expd[k]);
            e = exp_q.pop_front(); n_vec++;
            if (readdata !== e) begin
                n_err++; $display("FAIL tb_ro_addr%0d: got %h required %h", addrs[k], readdata, e);
            end
        end
        rd(3'd5, 16'h0000);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL tb_force_reads0: got %h required %h", readdata, e);
        end
        wr(3'd1, 16'hFFFF);
        rd(3'd1, 16'h00FF);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL tb_mask_width: got %h required %h", readdata, e);
        end
        wr(3'd0, 16'h0010);
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0000);
        tick(2);
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL tb_irq_idle: got %b required 0", irq);
        end
    endtask

    task automatic test_timer;
        logic        line, expv, prev;
        logic        q[$];
        int unsigned tcnt, isr, rises, last_rise;
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0001);
        q = '{1'b0, 1'b0, 1'b0};
        line = 1'b0; prev = 1'b0;
        tcnt = TIMER_LOAD; isr = 0; rises = 0; last_rise = 0;
        for (int unsigned cyc = 0; cyc < 3 * (TIMER_LOAD + 1) + 50; cyc++) begin
            expv = q.pop_front(); n_vec++;
            if (irq !== expv) begin
                n_err++; $display("FAIL t6_irq_cycle%0d: got %b required %b", cyc, irq, expv);
            end
            if (irq === 1'b1 && prev === 1'b0) begin
                if (rises > 0) begin
                    n_vec++;
                    if (cyc - last_rise != TIMER_LOAD + 1) begin
                        n_err++;
                        $display("FAIL t6_period: got %0d required %0d", cyc - last_rise, TIMER_LOAD + 1);
                    end
                end
                rises++;
                last_rise = cyc;
            end
            prev = irq;
            if (tcnt == 0) begin
                line = 1'b1; tcnt = TIMER_LOAD; isr = 0;
            end else begin
                tcnt--;
            end
            if (line) begin
                isr++;
                if (isr == ISR_DELAY) line = 1'b0;
            end
            irq_in[0] = line;
            q.push_back(line);
            @(negedge clk);
        end
        n_vec++;
        if (rises != 3) begin
            n_err++; $display("FAIL t6_rise_count: got %0d required 3", rises);
        end
        irq_in = '0;
        tick(3);
    endtask

    task automatic test_reset_mid;
        wr(3'd2, 16'h0001);
        wr(3'd1, 16'h0001);
        wr(3'd5, 16'h0001);
        tick(1);
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL tr_irq_forced: got %b required 1", irq);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL tr_irq_reset: got %b required 0", irq);
        end
        rd(3'd1, 16'h0000);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL tr_mask_reset: got %h required %h", readdata, e);
        end
        rd(3'd2, 16'h0000);
        e = exp_q.pop_front(); n_vec++;
        if (readdata !== e) begin
            n_err++; $display("FAIL tr_edge_reset: got %h required %h", readdata, e);
        end
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        irq_in     = '0;
        test_reset();
        test_level();
        test_edge_latch();
        test_collision();
        test_mask_force();
        test_boundary();
        test_timer();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
